// File: rtl/alu_mul_seq.sv
// Sequential 16x16 shift-add multiplier (low 16 bits of a*b) that performs every
// add on the shared 16-bit ALU: acc += mcand for each set multiplier bit, mcand doubles per bit.
module alu_mul_seq #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_zr,
  output logic        res_ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctl,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DBL,
    DONE
  } state_t;

  // ALU control words {zx,nx,zy,ny,f,no}
  localparam logic [5:0] CTL_ADD   = 6'b000010;
  localparam logic [5:0] CTL_PASSX = 6'b001100;
  localparam logic [5:0] CTL_ZERO  = 6'b101010;

  state_t      state, state_next;
  logic [15:0] acc, acc_next;
  logic [15:0] mcand, mcand_next;
  logic [15:0] mplr, mplr_next;
  logic [4:0]  cnt, cnt_next;
  logic [15:0] mplr_shift;

  assign mplr_shift = mplr >> 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      mcand <= mcand_next;
      mplr  <= mplr_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    mcand_next = mcand;
    mplr_next  = mplr;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    res_zr     = 1'b0;
    res_ng     = 1'b0;
    alu_x      = '0;
    alu_y      = '0;
    alu_ctl    = CTL_ZERO;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          acc_next   = '0;
          mcand_next = req_a;
          mplr_next  = req_b;
          cnt_next   = '0;
          if (EARLY_EXIT && (req_b == 16'd0)) begin
            state_next = DONE;
          end else if (req_b[0]) begin
            state_next = ADD;
          end else begin
            state_next = DBL;
          end
        end
      end

      ADD: begin
        alu_x      = acc;
        alu_y      = mcand;
        alu_ctl    = CTL_ADD;
        acc_next   = alu_out;
        state_next = DBL;
      end

      // Doubling mcand through the ALU (mcand+mcand) consumes one multiplier bit
      DBL: begin
        alu_x      = mcand;
        alu_y      = mcand;
        alu_ctl    = CTL_ADD;
        mcand_next = alu_out;
        mplr_next  = mplr_shift;
        cnt_next   = cnt + 5'd1;
        if ((EARLY_EXIT && (mplr_shift == 16'd0)) || (cnt == 5'd15)) begin
          state_next = DONE;
        end else if (mplr_shift[0]) begin
          state_next = ADD;
        end else begin
          state_next = DBL;
        end
      end

      DONE: begin
        res_valid = 1'b1;
        alu_x     = acc;
        alu_ctl   = CTL_PASSX;
        res_data  = acc;
        res_zr    = alu_zr;
        res_ng    = alu_ng;
        if (res_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort wins over any handshake; datapath registers simply hold
    if (clear) begin
      state_next = IDLE;
      acc_next   = acc;
      mcand_next = mcand;
      mplr_next  = mplr;
      cnt_next   = cnt;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: a behavioural ALU feeds the DUT, requests push
// expected {product, latency} into a queue, and a monitor pops/compares on each result.
module tb_alu_mul_seq;

  localparam logic [5:0] CTL_ADD   = 6'b000010;
  localparam logic [5:0] CTL_PASSX = 6'b001100;
  localparam logic [5:0] CTL_ZERO  = 6'b101010;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    int          lat;
    int          acc_cycle;
    bit          seen;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_zr;
  logic        res_ng;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;

  logic        e0_req_valid;
  logic        e0_req_ready;
  logic [15:0] e0_req_a;
  logic [15:0] e0_req_b;
  logic        e0_res_valid;
  logic        e0_res_ready = 1'b1;
  logic        e0_clear = 1'b0;
  logic [15:0] e0_res_data;
  logic        e0_res_zr;
  logic        e0_res_ng;
  logic [15:0] e0_alu_x;
  logic [15:0] e0_alu_y;
  logic [5:0]  e0_alu_ctl;
  logic [15:0] e0_alu_out;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cycle_count = 0;
  bit   hold_ready = 1'b0;

  alu_mul_seq #(.EARLY_EXIT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zr(res_zr), .res_ng(res_ng),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  alu_mul_seq #(.EARLY_EXIT(1'b0)) dut_e0 (
    .clk(clk), .reset_n(reset_n), .clear(e0_clear),
    .req_valid(e0_req_valid), .req_ready(e0_req_ready), .req_a(e0_req_a), .req_b(e0_req_b),
    .res_valid(e0_res_valid), .res_ready(e0_res_ready), .res_data(e0_res_data),
    .res_zr(e0_res_zr), .res_ng(e0_res_ng),
    .alu_x(e0_alu_x), .alu_y(e0_alu_y), .alu_ctl(e0_alu_ctl),
    .alu_out(e0_alu_out), .alu_zr(e0_alu_out == 16'd0), .alu_ng(e0_alu_out[15])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_count++;

  // Hack-style ALU: optional zero/negate of each input, add or and, optional output negate
  function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                        input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out    = alu_f(alu_x, alu_y, alu_ctl);
  assign alu_zr     = (alu_out == 16'd0);
  assign alu_ng     = alu_out[15];
  assign e0_alu_out = alu_f(e0_alu_x, e0_alu_y, e0_alu_ctl);

  function automatic int exp_latency(input logic [15:0] b, input bit early);
    int pc = 0;
    int msb = -1;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        pc++;
        msb = i;
      end
    end
    if (!early) return pc + 16;
    if (b == 16'd0) return 0;
    return pc + msb + 1;
  endfunction

  function automatic logic [15:0] exp_product(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    return p[15:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check_output("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid   = 1'b1;
    req_a       = a;
    req_b       = b;
    e.a         = a;
    e.b         = b;
    e.data      = exp_product(a, b);
    e.lat       = exp_latency(b, 1'b1);
    e.acc_cycle = cycle_count + 1;
    e.seen      = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((exp_q.size() != 0 || !req_ready) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) check_output("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_output({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_output({tag, "_res_data"}, 32'(res_data), 32'd0);
    check_output({tag, "_alu_x"}, 32'(alu_x), 32'd0);
    check_output({tag, "_alu_y"}, 32'(alu_y), 32'd0);
    check_output({tag, "_alu_ctl"}, 32'(alu_ctl), 32'(CTL_ZERO));
  endtask

  task automatic run_no_early(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    @(negedge clk);
    check_output("e0_req_ready", 32'(e0_req_ready), 32'd1);
    e0_req_valid = 1'b1;
    e0_req_a     = a;
    e0_req_b     = b;
    @(negedge clk);
    e0_req_valid = 1'b0;
    while (!e0_res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("e0_latency", 32'(n), 32'(exp_latency(b, 1'b0)));
    check_output("e0_res_data", 32'(e0_res_data), 32'(exp_product(a, b)));
  endtask

  // Monitor: random back-pressure, latency on first sight, stable result while held
  always @(negedge clk) begin
    bit rr;
    int elapsed;
    if (reset_n) begin
      rr = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      res_ready <= rr;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_result", 32'(res_valid), 32'd0);
        end else begin
          if (!exp_q[0].seen) begin
            elapsed = cycle_count - exp_q[0].acc_cycle;
            check_output("latency", 32'(elapsed), 32'(exp_q[0].lat));
            exp_q[0].seen = 1'b1;
          end
          check_output("res_data", 32'(res_data), 32'(exp_q[0].data));
          check_output("res_zr", 32'(res_zr), 32'(exp_q[0].data == 16'd0));
          check_output("res_ng", 32'(res_ng), 32'(exp_q[0].data[15]));
          check_output("done_alu_ctl", 32'(alu_ctl), 32'(CTL_PASSX));
          check_output("done_req_ready", 32'(req_ready), 32'd0);
          if (rr) void'(exp_q.pop_front());
        end
      end else if (req_ready) begin
        check_output("idle_alu_ctl", 32'(alu_ctl), 32'(CTL_ZERO));
      end else begin
        check_output("busy_alu_ctl", 32'(alu_ctl), 32'(CTL_ADD));
        if (exp_q.size() != 0 && !exp_q[0].seen &&
            (cycle_count - exp_q[0].acc_cycle) > 40) begin
          check_output("result_timeout", 32'(res_valid), 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int waited;
    reset_n      = 1'b0;
    clear        = 1'b0;
    req_valid    = 1'b0;
    req_a        = '0;
    req_b        = '0;
    e0_req_valid = 1'b0;
    e0_req_a     = '0;
    e0_req_b     = '0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    apply_stimulus(16'd3, 16'd5);
    apply_stimulus(16'h1234, 16'd0);
    apply_stimulus(16'hFFFF, 16'hFFFF);
    apply_stimulus(16'hFFFE, 16'd3);
    apply_stimulus(16'd0, 16'h8000);
    apply_stimulus(16'h8000, 16'd2);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      apply_stimulus(ra, rb);
    end
    wait_idle();

    // Result held through ten stalled cycles while a competing request is ignored
    hold_ready = 1'b1;
    apply_stimulus(16'd3, 16'd5);
    waited = 0;
    while (!res_valid && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check_output("stall_reached_done", 32'(res_valid), 32'd1);
    req_valid = 1'b1;
    req_a     = 16'd9;
    req_b     = 16'd9;
    repeat (10) @(negedge clk);
    req_valid  = 1'b0;
    hold_ready = 1'b0;
    wait_idle();

    // Synchronous abort in the third cycle of a 7*9 operation
    apply_stimulus(16'd7, 16'd9);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clear = 1'b0;
    check_output("clear_req_ready", 32'(req_ready), 32'd1);
    check_output("clear_res_valid", 32'(res_valid), 32'd0);
    apply_stimulus(16'd2, 16'd2);
    wait_idle();

    // Asynchronous reset mid-operation takes effect without a clock edge
    apply_stimulus(16'd7, 16'd9);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(16'd2, 16'd2);
    wait_idle();

    run_no_early(16'hFFFF, 16'hFFFF);
    run_no_early(16'd3, 16'd5);
    run_no_early(16'h1234, 16'd0);
    run_no_early(16'hFFFE, 16'd3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
